// File: rtl/uart_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_responder_if
// Brief    : Byte-stream and status bundle between the UART pair and responder.
// Revision : 1.0
// ============================================================================
interface uart_mem_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       err;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, busy, err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_responder
// Brief    : Far-end 18-bit word memory serving the DMA UART read/write protocol.
// Revision : 1.0
// ============================================================================
module uart_mem_responder #(
  parameter int         MEM_WORDS      = 1024,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_mem_responder_if.slave  bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_COUNT,
    S_WDATA, S_WCOMMIT, S_ACK, S_RFETCH, S_RSEND
  } state_t;

  state_t          r_state, w_next;
  logic            r_is_write;
  logic [17:0]     r_addr;
  logic [5:0]      r_words;
  logic [1:0]      r_idx;
  logic [17:0]     r_wword;
  logic [17:0]     r_rword;
  logic [TW-1:0]   r_tmo;
  logic [17:0]     mem [MEM_WORDS];

  logic            w_tmo_state;
  logic            w_timeout;
  logic [AW-1:0]   w_index;

  assign w_index     = AW'(r_addr) & AW'(MEM_WORDS - 1);
  assign w_tmo_state = (r_state == S_ADDR2) || (r_state == S_ADDR1) ||
                       (r_state == S_ADDR0) || (r_state == S_COUNT) ||
                       (r_state == S_WDATA);
  assign w_timeout   = w_tmo_state && !bus.rx_valid && (r_tmo == TO_LAST);
  assign bus.busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.err      = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    if (w_timeout) begin
      w_next  = S_IDLE;
      bus.err = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == 8'h00 || bus.rx_data == 8'h01) w_next = S_ADDR2;
            else bus.err = 1'b1;
          end
        end
        S_ADDR2: if (bus.rx_valid) w_next = S_ADDR1;
        S_ADDR1: if (bus.rx_valid) w_next = S_ADDR0;
        S_ADDR0: if (bus.rx_valid) w_next = S_COUNT;
        S_COUNT: if (bus.rx_valid) w_next = r_is_write ? S_WDATA : S_RFETCH;
        S_WDATA: if (bus.rx_valid && r_idx == 2'd2) w_next = S_WCOMMIT;
        S_WCOMMIT: begin
          bus.err = bus.rx_valid;
          w_next  = (r_words == 6'd1) ? S_ACK : S_WDATA;
        end
        S_ACK: begin
          bus.err      = bus.rx_valid;
          bus.tx_valid = 1'b1;
          bus.tx_data  = ACK_BYTE;
          if (bus.tx_ready) w_next = S_IDLE;
        end
        S_RFETCH: begin
          bus.err = bus.rx_valid;
          w_next  = S_RSEND;
        end
        S_RSEND: begin
          bus.err      = bus.rx_valid;
          bus.tx_valid = 1'b1;
          case (r_idx)
            2'd0:    bus.tx_data = {6'b0, r_rword[17:16]};
            2'd1:    bus.tx_data = r_rword[15:8];
            default: bus.tx_data = r_rword[7:0];
          endcase
          if (bus.tx_ready && r_idx == 2'd2)
            w_next = (r_words == 6'd1) ? S_IDLE : S_RFETCH;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_words    <= '0;
      r_idx      <= '0;
      r_wword    <= '0;
      r_tmo      <= '0;
    end else begin
      // Idle time since the last received byte, only while a command is arriving
      if (w_tmo_state && !bus.rx_valid) r_tmo <= r_tmo + 1'b1;
      else                              r_tmo <= '0;

      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (bus.rx_valid) r_is_write <= bus.rx_data[0];
        end
        S_ADDR2: if (bus.rx_valid) r_addr[17:16] <= bus.rx_data[1:0];
        S_ADDR1: if (bus.rx_valid) r_addr[15:8]  <= bus.rx_data;
        S_ADDR0: if (bus.rx_valid) r_addr[7:0]   <= bus.rx_data;
        S_COUNT: begin
          if (bus.rx_valid) begin
            r_words <= (bus.rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, bus.rx_data[4:0]};
            r_idx   <= '0;
          end
        end
        S_WDATA: begin
          if (bus.rx_valid) begin
            case (r_idx)
              2'd0:    r_wword[17:16] <= bus.rx_data[1:0];
              2'd1:    r_wword[15:8]  <= bus.rx_data;
              default: r_wword[7:0]   <= bus.rx_data;
            endcase
            r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
          end
        end
        S_WCOMMIT: begin
          r_words <= r_words - 6'd1;
          r_addr  <= r_addr + 18'd1;
        end
        S_RSEND: begin
          if (bus.tx_ready) begin
            if (r_idx == 2'd2) begin
              r_idx   <= '0;
              r_words <= r_words - 6'd1;
              r_addr  <= r_addr + 18'd1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory is deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (r_state == S_WCOMMIT) mem[w_index] <= r_wword;
    if (r_state == S_RFETCH)  r_rword      <= mem[w_index];
  end

endmodule
`default_nettype wire
